// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/ready pipeline stage with 2-entry skid, flush and occupancy
module pipe_stage_buf #(
  parameter int DW = 64,
  parameter logic [DW-1:0] NOP = '0
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  input  logic          flush,
  output logic [1:0]    occupancy
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state, state_nx;
  logic [DW-1:0] main_q, skid_q, main_nx, skid_nx;
  logic inx, outx;
  assign out_valid = state != EMPTY;
  assign in_ready  = state != FULL;
  assign occupancy = state == FULL ? 2'd2 : state == ONE ? 2'd1 : 2'd0;
  assign out_data  = main_q;
  assign inx  = in_valid & in_ready;
  assign outx = out_valid & out_ready;
  always_comb begin
    state_nx = state;
    main_nx  = main_q;
    skid_nx  = skid_q;
    if (flush) begin
      state_nx = EMPTY;
      main_nx  = NOP;
    end else begin
      case (state)
        EMPTY: if (inx) begin
          main_nx  = in_data;
          state_nx = ONE;
        end
        ONE: if (inx && outx) main_nx = in_data;
        else if (inx) begin
          skid_nx  = in_data;
          state_nx = FULL;
        end else if (outx) begin
          main_nx  = NOP;
          state_nx = EMPTY;
        end
        FULL: if (outx) begin
          main_nx  = skid_q;
          state_nx = ONE;
        end
        default: begin
          state_nx = EMPTY;
          main_nx  = NOP;
        end
      endcase
    end
  end
  // state advances on the falling edge so the stage aligns with the rest of the pipeline
  always_ff @(negedge clk or negedge clrn) begin
    if (!clrn) begin
      state  <= EMPTY;
      main_q <= NOP;
      skid_q <= '0;
    end else begin
      state  <= state_nx;
      main_q <= main_nx;
      skid_q <= skid_nx;
    end
  end
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed and scoreboard checks for pipe_stage_buf
module tb_pipe_stage_buf;
  logic        clk = 0, clrn = 0, in_valid = 0, out_ready = 0, flush = 0;
  logic        in_ready, out_valid;
  logic [63:0] in_data = '0, out_data;
  logic [1:0]  occupancy;
  logic [67:0] obs;
  int checks = 0, errors = 0;

  pipe_stage_buf #(.DW(64), .NOP(64'h0)) dut (
    .clk(clk), .clrn(clrn), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .occupancy(occupancy)
  );

  always #5 clk = ~clk;
  assign obs = {out_valid, in_ready, occupancy, out_data};

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (obs !== {1'b0, 1'b1, 2'd0, 64'h0}) begin
      errors++;
      $display("FAIL reset: got %h want %h", obs, {1'b0, 1'b1, 2'd0, 64'h0});
    end
    #5 clrn = 1;
    cyc();
    checks++;
    if (obs !== {1'b0, 1'b1, 2'd0, 64'h0}) begin
      errors++;
      $display("FAIL reset_idle: got %h want %h", obs, {1'b0, 1'b1, 2'd0, 64'h0});
    end
  endtask

  task automatic test_stream();
    out_ready = 1;
    in_valid  = 1;
    for (int i = 0; i < 4; i++) begin
      in_data = 64'h11 + 64'(i);
      cyc();
      checks++;
      if (obs !== {1'b1, 1'b1, 2'd1, 64'h11 + 64'(i)}) begin
        errors++;
        $display("FAIL stream%0d: got %h want %h", i, obs, {1'b1, 1'b1, 2'd1, 64'h11 + 64'(i)});
      end
    end
    in_valid = 0;
    cyc();
    checks++;
    if (obs !== {1'b0, 1'b1, 2'd0, 64'h0}) begin
      errors++;
      $display("FAIL stream_drain: got %h want %h", obs, {1'b0, 1'b1, 2'd0, 64'h0});
    end
  endtask

  task automatic test_stall();
    logic [67:0] exp [5];
    exp[0] = {1'b1, 1'b1, 2'd1, 64'hA1};
    exp[1] = {1'b1, 1'b0, 2'd2, 64'hA1};
    exp[2] = {1'b1, 1'b0, 2'd2, 64'hA1};
    exp[3] = {1'b1, 1'b1, 2'd1, 64'hA2};
    exp[4] = {1'b1, 1'b1, 2'd1, 64'hA3};
    out_ready = 0;
    in_valid  = 1;
    for (int i = 0; i < 5; i++) begin
      in_data   = i == 0 ? 64'hA1 : i == 1 ? 64'hA2 : 64'hA3;
      out_ready = i >= 3;
      cyc();
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL stall%0d: got %h want %h", i, obs, exp[i]);
      end
    end
    in_valid = 0;
    cyc();
    checks++;
    if (obs !== {1'b0, 1'b1, 2'd0, 64'h0}) begin
      errors++;
      $display("FAIL stall_end: got %h want %h", obs, {1'b0, 1'b1, 2'd0, 64'h0});
    end
  endtask

  task automatic test_flush();
    out_ready = 0;
    in_valid  = 1;
    in_data   = 64'hB1;
    cyc();
    in_data = 64'hB2;
    cyc();
    checks++;
    if (obs !== {1'b1, 1'b0, 2'd2, 64'hB1}) begin
      errors++;
      $display("FAIL flush_fill: got %h want %h", obs, {1'b1, 1'b0, 2'd2, 64'hB1});
    end
    in_data = 64'hB3;
    flush   = 1;
    cyc();
    flush = 0;
    checks++;
    if (obs !== {1'b0, 1'b1, 2'd0, 64'h0}) begin
      errors++;
      $display("FAIL flush_full: got %h want %h", obs, {1'b0, 1'b1, 2'd0, 64'h0});
    end
    in_valid  = 0;
    out_ready = 1;
    cyc();
    checks++;
    if (obs !== {1'b0, 1'b1, 2'd0, 64'h0}) begin
      errors++;
      $display("FAIL flush_no_b3: got %h want %h", obs, {1'b0, 1'b1, 2'd0, 64'h0});
    end
    in_valid = 1;
    in_data  = 64'hB4;
    cyc();
    in_data = 64'hB5;
    flush   = 1;
    cyc();
    flush    = 0;
    in_valid = 0;
    checks++;
    if (obs !== {1'b0, 1'b1, 2'd0, 64'h0}) begin
      errors++;
      $display("FAIL flush_one_inx: got %h want %h", obs, {1'b0, 1'b1, 2'd0, 64'h0});
    end
  endtask

  task automatic test_drain();
    out_ready = 0;
    in_valid  = 1;
    in_data   = 64'hC1;
    cyc();
    checks++;
    if (obs !== {1'b1, 1'b1, 2'd1, 64'hC1}) begin
      errors++;
      $display("FAIL drain_load: got %h want %h", obs, {1'b1, 1'b1, 2'd1, 64'hC1});
    end
    in_valid  = 0;
    out_ready = 1;
    cyc();
    checks++;
    if (obs !== {1'b0, 1'b1, 2'd0, 64'h0}) begin
      errors++;
      $display("FAIL drain: got %h want %h", obs, {1'b0, 1'b1, 2'd0, 64'h0});
    end
  endtask

  task automatic test_async_reset();
    out_ready = 0;
    in_valid  = 1;
    in_data   = 64'hE1;
    cyc();
    in_data = 64'hE2;
    cyc();
    in_valid = 0;
    checks++;
    if (obs !== {1'b1, 1'b0, 2'd2, 64'hE1}) begin
      errors++;
      $display("FAIL areset_fill: got %h want %h", obs, {1'b1, 1'b0, 2'd2, 64'hE1});
    end
    #1 clrn = 0;
    #1;
    checks++;
    if (obs !== {1'b0, 1'b1, 2'd0, 64'h0}) begin
      errors++;
      $display("FAIL areset_async: got %h want %h", obs, {1'b0, 1'b1, 2'd0, 64'h0});
    end
    #1 clrn = 1;
    out_ready = 1;
    cyc();
    checks++;
    if (obs !== {1'b0, 1'b1, 2'd0, 64'h0}) begin
      errors++;
      $display("FAIL areset_no_replay: got %h want %h", obs, {1'b0, 1'b1, 2'd0, 64'h0});
    end
  endtask

  task automatic test_random();
    logic [63:0] q[$];
    logic [63:0] exp_data;
    logic        inx, outx;
    for (int n = 0; n < 10000; n++) begin
      exp_data = q.size() > 0 ? q[0] : 64'h0;
      checks++;
      if (obs !== {q.size() > 0, q.size() < 2, 2'(q.size()), exp_data}) begin
        errors++;
        if (errors < 20)
          $display("FAIL random@%0d: got %h want %h", n, obs, {q.size() > 0, q.size() < 2, 2'(q.size()), exp_data});
      end
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      flush     = $urandom_range(0, 19) == 0;
      in_data   = {$urandom, $urandom};
      inx  = in_valid && q.size() < 2;
      outx = out_ready && q.size() > 0;
      cyc();
      if (outx) void'(q.pop_front());
      if (flush) q.delete();
      else if (inx) q.push_back(in_data);
    end
    in_valid = 0;
    flush    = 0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_drain();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline stage register with a valid/ready handshake on both sides, a 2-entry skid buffer, a synchronous flush that inserts a bubble, and an occupancy output. It is the general stage register for the pipeline: it replaces fixed-width hold-only stage registers between IF/ID, ID/EX and later stages. Backpressure from a stalled downstream stage is absorbed without a combinational ready path, and a mispredicted branch or exception can squash the stage in one edge.

## Interface
- DW, 64: payload width in bits; the payload is, for example, {instruction, pc4}.
- NOP, {DW{1'b0}}: bubble payload driven on out_data whenever the stage is empty.

- clk  in  1  clock; all state updates on the falling edge.
- clrn  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream presents in_data.
- in_ready  out  1  stage can accept; a transfer happens when in_valid & in_ready at an edge.
- in_data  in  DW  upstream payload.
- out_valid  out  1  out_data holds a live entry.
- out_ready  in  1  downstream accepts; a transfer happens when out_valid & out_ready at an edge. Low means stall.
- out_data  out  DW  payload to downstream.
- flush  in  1  synchronous squash of all held entries.
- occupancy  out  2  number of held entries, 0..2.

## Operation
- Storage:
  - main register drives out_data.
  - skid register holds the second entry.
  - state is one of EMPTY, ONE or FULL.
- Outputs decode from state registers only:
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL).
  - occupancy: EMPTY=0, ONE=1, FULL=2.
  - There is no combinational path from out_ready or in_valid to any output.
- Let inx = in_valid & in_ready and outx = out_valid & out_ready. Transitions:
  - EMPTY, inx: main <= in_data, go to ONE.
  - EMPTY, no inx: main holds NOP.
  - ONE, inx & outx: main <= in_data, stay in ONE.
  - ONE, inx only: skid <= in_data, go to FULL.
  - ONE, outx only: main <= NOP, go to EMPTY.
  - ONE, neither: hold.
  - FULL, outx: main <= skid, go to ONE. in_valid is ignored because in_ready=0.
  - FULL, no outx: hold.
- Ordering is strict FIFO. The skid entry never bypasses main.
- flush has top priority:
  - At an edge with flush=1: state <= EMPTY and main <= NOP.
  - The skid contents become don't-care.
  - An input accepted at that same edge (inx=1) is discarded.
  - An output transfer at that same edge (outx=1) still counts as delivered downstream, because the downstream sampled out_data at that edge.
- Payload is opaque. No arithmetic or width conversion is performed; all DW bits pass unmodified.

## Timing
- Reset (clrn=0, asynchronous, independent of clk):
  - state=EMPTY, out_valid=0, in_ready=1, occupancy=0.
  - out_data=NOP, skid=0.
- Release of clrn is synchronised by the system. The first transfer can occur at the first falling edge after release.
- Latency: data accepted at falling edge n is on out_data with out_valid=1 immediately after edge n, when the stage was empty or draining.
- Throughput: one transfer per cycle sustained while out_ready=1.
- Stall:
  - While out_valid=1 and out_ready=0, out_data and out_valid are stable.
  - One further entry is accepted into skid, then in_ready drops after that edge.
- Releasing a stall from FULL:
  - First edge with out_ready=1: main <= skid, and in_ready returns to 1 after that edge.
  - No entry is lost or duplicated.
- Reset asserted mid-operation drops all entries immediately. Nothing is replayed.
- Simultaneous flush and clrn=0: reset wins (same end state).

## Test plan
- Reset, then in_valid=1 for 4 edges with data 0x11..0x14 and out_ready=1: out_data shows 0x11, 0x12, 0x13, 0x14 on consecutive cycles, occupancy=1 throughout, in_ready=1 throughout.
- Stall:
  - Stimulus: after 0xA1 is in main, hold out_ready=0 and offer 0xA2, then 0xA3.
  - Required: 0xA2 is accepted, in_ready=0 and occupancy=2, 0xA3 is held upstream. Raising out_ready then delivers 0xA1, 0xA2, 0xA3 in order.
- Flush from FULL (0xB1 in main, 0xB2 in skid), with in_valid=1 carrying 0xB3 at the flush edge: next cycle out_valid=0, out_data=NOP, occupancy=0, and 0xB3 never appears.
- Drain: single entry 0xC1, no new input, out_ready=1: after one edge out_valid=0 and out_data=NOP.
- Async reset mid-stall (FULL state), clrn pulsed low between edges: outputs go to the reset values immediately without a clock edge, and in_ready=1.
- Random valid/ready/flush with a scoreboard over 10k cycles: the output sequence equals the accepted inputs minus flushed entries. Check no duplicates, no reordering, and occupancy matches the model.
